// File: rtl/te_branch_map.sv
`default_nettype none
// ============================================================================
// Module      : te_branch_map
// Description : Branch-map accumulator for the trace encoder. Collects up to
//               LANES taken/not-taken outcomes per cycle into a bit map of
//               MAX_BRANCHES entries, with flush/reload and overflow report.
// Revision    : 1.0 - initial multi-lane, parametrised release
// ============================================================================
module te_branch_map #(
    parameter int MAX_BRANCHES = 31,
    parameter int LANES        = 1,
    parameter int CNT_W        = $clog2(MAX_BRANCHES + 1),
    parameter int LANE_W       = $clog2(LANES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic [LANE_W-1:0]       branch_cnt_i,
    input  logic [LANES-1:0]        branch_nt_i,
    input  logic                    flush_i,
    output logic [MAX_BRANCHES-1:0] map_o,
    output logic [CNT_W-1:0]        count_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    overflow_o
);

    localparam logic [CNT_W:0]    c_max_wide = (CNT_W + 1)'(MAX_BRANCHES);
    localparam logic [CNT_W-1:0]  c_max      = CNT_W'(MAX_BRANCHES);
    localparam logic [LANE_W-1:0] c_lanes    = LANE_W'(LANES);

    logic [MAX_BRANCHES-1:0] r_map;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;

    logic [LANE_W-1:0]       w_n;
    logic [CNT_W:0]          w_base;
    logic [CNT_W:0]          w_sum;
    logic [MAX_BRANCHES-1:0] w_map_next;
    logic [CNT_W-1:0]        w_count_next;
    logic                    w_overflow_next;

    // Effective lane count (clamped), write base and next map/count/overflow
    always_comb begin
        w_n             = '0;
        w_base          = '0;
        w_sum           = '0;
        w_map_next      = '0;
        w_count_next    = '0;
        w_overflow_next = 1'b0;

        if (valid_i) begin
            w_n = (branch_cnt_i > c_lanes) ? c_lanes : branch_cnt_i;
        end

        // A flush restarts the map at bit 0; stale bits are cleared here so
        // every bit at or above the count stays zero.
        w_base     = flush_i ? '0 : {1'b0, r_count};
        w_map_next = flush_i ? '0 : r_map;
        w_sum      = w_base + (CNT_W + 1)'(w_n);

        // Lanes that land past the last slot are simply not written.
        for (int b = 0; b < MAX_BRANCHES; b++) begin
            for (int k = 0; k < LANES; k++) begin
                if ((k < int'(w_n)) && ((int'(w_base) + k) == b)) begin
                    w_map_next[b] = branch_nt_i[k];
                end
            end
        end

        if (w_sum > c_max_wide) begin
            w_count_next    = c_max;
            w_overflow_next = !flush_i;
        end else begin
            w_count_next    = w_sum[CNT_W-1:0];
        end
    end

    // Map, count and overflow pulse registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_map      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_map      <= w_map_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign map_o      = r_map;
    assign count_o    = r_count;
    assign empty_o    = (r_count == '0);
    assign full_o     = (r_count == c_max);
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_te_branch_map.sv
`default_nettype none
// ============================================================================
// Module      : tb_te_branch_map
// Description : Directed bench for te_branch_map: a 4-lane/8-entry instance
//               driven from a vector table and a 1-lane/31-entry instance
//               driven through a full single-lane fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_te_branch_map;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- 4-lane, 8-entry instance ----------------
    logic       rst8_n  = 1'b0;
    logic       valid8  = 1'b0;
    logic [2:0] cnt8    = '0;
    logic [3:0] nt8     = '0;
    logic       flush8  = 1'b0;
    logic [7:0] map8;
    logic [3:0] count8;
    logic       empty8, full8, ovf8;

    te_branch_map #(.MAX_BRANCHES(8), .LANES(4)) u_dut8 (
        .clk_i        (clk),
        .rst_ni       (rst8_n),
        .valid_i      (valid8),
        .branch_cnt_i (cnt8),
        .branch_nt_i  (nt8),
        .flush_i      (flush8),
        .map_o        (map8),
        .count_o      (count8),
        .empty_o      (empty8),
        .full_o       (full8),
        .overflow_o   (ovf8)
    );

    // ---------------- 1-lane, 31-entry instance ----------------
    logic        rst31_n = 1'b0;
    logic        valid31 = 1'b0;
    logic [0:0]  cnt31   = '0;
    logic [0:0]  nt31    = '0;
    logic        flush31 = 1'b0;
    logic [30:0] map31;
    logic [4:0]  count31;
    logic        empty31, full31, ovf31;

    te_branch_map #(.MAX_BRANCHES(31), .LANES(1)) u_dut31 (
        .clk_i        (clk),
        .rst_ni       (rst31_n),
        .valid_i      (valid31),
        .branch_cnt_i (cnt31),
        .branch_nt_i  (nt31),
        .flush_i      (flush31),
        .map_o        (map31),
        .count_o      (count31),
        .empty_o      (empty31),
        .full_o       (full31),
        .overflow_o   (ovf31)
    );

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [2:0] cnt;
        logic [3:0] nt;
        logic       flush;
        logic [7:0] exp_map;
        logic [3:0] exp_cnt;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [2:0] c,
                       input logic [3:0] n, input logic f, input logic [7:0] em,
                       input logic [3:0] ec, input logic ee, input logic ef,
                       input logic eo);
        vec_t t;
        t.rst_n = r; t.valid = v; t.cnt = c; t.nt = n; t.flush = f;
        t.exp_map = em; t.exp_cnt = ec; t.exp_empty = ee;
        t.exp_full = ef; t.exp_ovf = eo;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // rst v cnt nt flush | map cnt empty full ovf
        add(0, 1, 3'd4, 4'b1111, 1, 8'b0000_0000, 4'd0, 1, 0, 0); // 0 reset
        add(0, 1, 3'd4, 4'b1111, 1, 8'b0000_0000, 4'd0, 1, 0, 0); // 1 reset
        add(1, 0, 3'd0, 4'b0000, 0, 8'b0000_0000, 4'd0, 1, 0, 0); // 2 idle
        add(1, 1, 3'd3, 4'b0101, 0, 8'b0000_0101, 4'd3, 0, 0, 0); // 3
        add(1, 1, 3'd4, 4'b1110, 0, 8'b0111_0101, 4'd7, 0, 0, 0); // 4 ordering
        add(1, 1, 3'd2, 4'b0010, 1, 8'b0000_0010, 4'd2, 0, 0, 0); // 5 flush+load
        add(1, 1, 3'd3, 4'b0001, 0, 8'b0000_0110, 4'd5, 0, 0, 0); // 6 count=5
        add(1, 1, 3'd2, 4'b0010, 1, 8'b0000_0010, 4'd2, 0, 0, 0); // 7 flush+load
        add(1, 0, 3'd0, 4'b0000, 1, 8'b0000_0000, 4'd0, 1, 0, 0); // 8 b2b flush
        add(1, 1, 3'd4, 4'b0011, 0, 8'b0000_0011, 4'd4, 0, 0, 0); // 9
        add(1, 1, 3'd2, 4'b0000, 0, 8'b0000_0011, 4'd6, 0, 0, 0); // 10 count=6
        add(1, 1, 3'd4, 4'b1111, 0, 8'b1100_0011, 4'd8, 0, 1, 1); // 11 overflow
        add(1, 0, 3'd0, 4'b0000, 0, 8'b1100_0011, 4'd8, 0, 1, 0); // 12 pulse ends
        add(1, 1, 3'd1, 4'b0001, 0, 8'b1100_0011, 4'd8, 0, 1, 1); // 13 drop at full
        add(1, 0, 3'd0, 4'b0000, 0, 8'b1100_0011, 4'd8, 0, 1, 0); // 14
        add(1, 1, 3'd7, 4'b1010, 1, 8'b0000_1010, 4'd4, 0, 0, 0); // 15 clamp to 4
        add(1, 0, 3'd3, 4'b1111, 0, 8'b0000_1010, 4'd4, 0, 0, 0); // 16 valid=0
        add(1, 1, 3'd1, 4'b0001, 0, 8'b0001_1010, 4'd5, 0, 0, 0); // 17 count=5
        add(0, 1, 3'd2, 4'b0011, 0, 8'b0000_0000, 4'd0, 1, 0, 0); // 18 mid reset
        add(1, 0, 3'd0, 4'b0000, 0, 8'b0000_0000, 4'd0, 1, 0, 0); // 19
        add(1, 1, 3'd0, 4'b1111, 0, 8'b0000_0000, 4'd0, 1, 0, 0); // 20 cnt=0
        add(1, 1, 3'd4, 4'b1001, 0, 8'b0000_1001, 4'd4, 0, 0, 0); // 21
        add(1, 1, 3'd4, 4'b0110, 0, 8'b0110_1001, 4'd8, 0, 1, 0); // 22 exact fill
        add(1, 1, 3'd4, 4'b1111, 1, 8'b0000_1111, 4'd4, 0, 0, 0); // 23 flush at full

        // Table-driven run of the 4-lane instance.
        for (int i = 0; i < vecs.size(); i++) begin
            rst8_n = vecs[i].rst_n;
            valid8 = vecs[i].valid;
            cnt8   = vecs[i].cnt;
            nt8    = vecs[i].nt;
            flush8 = vecs[i].flush;
            @(posedge clk);
            #1;
            check($sformatf("v%0d map", i),   32'(map8),   32'(vecs[i].exp_map));
            check($sformatf("v%0d count", i), 32'(count8), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d empty", i), 32'(empty8), 32'(vecs[i].exp_empty));
            check($sformatf("v%0d full", i),  32'(full8),  32'(vecs[i].exp_full));
            check($sformatf("v%0d ovf", i),   32'(ovf8),   32'(vecs[i].exp_ovf));
        end
        valid8 = 1'b0;
        flush8 = 1'b0;

        // Single-lane instance: reset with valid/flush asserted.
        rst31_n = 1'b0; valid31 = 1'b1; flush31 = 1'b1; cnt31 = 1'b1; nt31 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst31_n = 1'b1; valid31 = 1'b0; flush31 = 1'b0;
        check("l1 reset map",   32'(map31),   32'd0);
        check("l1 reset count", 32'(count31), 32'd0);
        check("l1 reset empty", 32'(empty31), 32'd1);
        check("l1 reset full",  32'(full31),  32'd0);
        check("l1 reset ovf",   32'(ovf31),   32'd0);

        // 31 single-lane appends alternating not-taken/taken.
        for (int i = 0; i < 31; i++) begin
            valid31 = 1'b1;
            cnt31   = 1'b1;
            nt31    = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("l1 fill%0d count", i), 32'(count31), 32'(i + 1));
            if (i < 30) check($sformatf("l1 fill%0d full", i), 32'(full31), 32'd0);
        end
        valid31 = 1'b0;
        check("l1 full map",  32'(map31),  32'h5555_5555);
        check("l1 full flag", 32'(full31), 32'd1);
        check("l1 full ovf",  32'(ovf31),  32'd0);

        // One extra branch past capacity.
        valid31 = 1'b1; nt31 = 1'b0;
        @(posedge clk);
        #1;
        valid31 = 1'b0;
        check("l1 ovf pulse", 32'(ovf31),   32'd1);
        check("l1 ovf map",   32'(map31),   32'h5555_5555);
        check("l1 ovf count", 32'(count31), 32'd31);
        @(posedge clk);
        #1;
        check("l1 ovf clear", 32'(ovf31),   32'd0);

        // Flush with an arrival reloads a single entry.
        valid31 = 1'b1; flush31 = 1'b1; nt31 = 1'b1;
        @(posedge clk);
        #1;
        valid31 = 1'b0; flush31 = 1'b0;
        check("l1 flush map",   32'(map31),   32'd1);
        check("l1 flush count", 32'(count31), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
